// File: rtl/apu_pkg.sv
// Shared APU definitions: register map, duty sequences and the length-counter load table.
package apu_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_SWEEP    = 2'd1;
    localparam logic [1:0] REG_TIMER_LO = 2'd2;
    localparam logic [1:0] REG_TIMER_HI = 2'd3;

    // Entry [n] is duty setting n; bit [i] is the output level at sequence index i.
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b11111001,
        8'b00011110,
        8'b00000110,
        8'b00000010
    };

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] len;
        len = 8'd0;
        case (idx)
            5'd0:  len = 8'd10;
            5'd1:  len = 8'd254;
            5'd2:  len = 8'd20;
            5'd3:  len = 8'd2;
            5'd4:  len = 8'd40;
            5'd5:  len = 8'd4;
            5'd6:  len = 8'd80;
            5'd7:  len = 8'd6;
            5'd8:  len = 8'd160;
            5'd9:  len = 8'd8;
            5'd10: len = 8'd60;
            5'd11: len = 8'd10;
            5'd12: len = 8'd14;
            5'd13: len = 8'd12;
            5'd14: len = 8'd26;
            5'd15: len = 8'd14;
            5'd16: len = 8'd12;
            5'd17: len = 8'd16;
            5'd18: len = 8'd24;
            5'd19: len = 8'd18;
            5'd20: len = 8'd48;
            5'd21: len = 8'd20;
            5'd22: len = 8'd96;
            5'd23: len = 8'd22;
            5'd24: len = 8'd192;
            5'd25: len = 8'd24;
            5'd26: len = 8'd72;
            5'd27: len = 8'd26;
            5'd28: len = 8'd16;
            5'd29: len = 8'd28;
            5'd30: len = 8'd32;
            5'd31: len = 8'd30;
            default: len = 8'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pulse_envelope.sv
// Envelope generator: start flag, divider and decay counter with optional loop.
// Shared by the pulse channels and the noise channel.
module pulse_envelope (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       qtr_tick_i,
    input  logic       start_i,
    input  logic       loop_i,
    input  logic       const_vol_i,
    input  logic [3:0] volume_i,
    output logic [3:0] vol_o
);

    logic       start_q, start_d;
    logic [3:0] div_q, div_d;
    logic [3:0] decay_q, decay_d;

    always_comb begin
        start_d = start_q;
        div_d   = div_q;
        decay_d = decay_q;
        if (qtr_tick_i) begin
            if (start_q) begin
                start_d = 1'b0;
                div_d   = volume_i;
                decay_d = 4'hF;
            end else if (div_q == 4'd0) begin
                div_d = volume_i;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (loop_i) begin
                    decay_d = 4'hF;
                end
            end else begin
                div_d = div_q - 4'd1;
            end
        end
        // A restart that lands on a tick is kept for the following tick.
        if (start_i) begin
            start_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            start_q <= 1'b0;
            div_q   <= 4'd0;
            decay_q <= 4'd0;
        end else begin
            start_q <= start_d;
            div_q   <= div_d;
            decay_q <= decay_d;
        end
    end

    assign vol_o = const_vol_i ? volume_i : decay_q;

endmodule

// File: rtl/pulse_channel_v2.sv
// Second-generation APU pulse channel: write-strobe driven timer and duty sequencer,
// length counter, and sweep unit with period write-back and overflow muting.
module pulse_channel_v2
    import apu_pkg::*;
#(
    parameter bit SWEEP_ONES_COMP = 1'b0,
    parameter int MIN_PERIOD      = 8,
    parameter int OUT_W           = 5
) (
    input  logic                    apu_clk,
    input  logic                    reset,
    input  logic                    qtr_tick,
    input  logic                    hlf_tick,
    input  logic                    wr_en,
    input  logic [1:0]              wr_addr,
    input  logic [7:0]              wr_data,
    input  logic                    ch_enable,
    output logic                    active,
    output logic signed [OUT_W-1:0] pulse_out
);

    logic [7:0]              ctrl_q, ctrl_d;
    logic [7:0]              sweep_q, sweep_d;
    logic [7:0]              periodLo_q, periodLo_d;
    logic [2:0]              periodHi_q, periodHi_d;
    logic [7:0]              len_q, len_d;
    logic [10:0]             timer_q, timer_d;
    logic [2:0]              seq_q, seq_d;
    logic [2:0]              sweepDiv_q, sweepDiv_d;
    logic                    sweepReload_q, sweepReload_d;
    logic                    active_q;
    logic signed [OUT_W-1:0] pulseOut_q, pulseOut_d;

    logic [10:0] period;
    logic [10:0] sweepDelta;
    logic [11:0] sweepTarget;
    logic        sweepMute;
    logic        sweepWriteBack;
    logic        envStart;
    logic        dutyBit;
    logic [3:0]  volume;

    assign period     = {periodHi_q, periodLo_q};
    assign sweepDelta = period >> sweep_q[2:0];
    assign envStart   = wr_en && (wr_addr == REG_TIMER_HI);

    always_comb begin
        if (sweep_q[3]) begin
            sweepTarget = {1'b0, period} - {1'b0, sweepDelta} - 12'(SWEEP_ONES_COMP);
        end else begin
            sweepTarget = {1'b0, period} + {1'b0, sweepDelta};
        end
    end

    assign sweepMute = (period < 11'(MIN_PERIOD)) || (!sweep_q[3] && sweepTarget[11]);
    assign sweepWriteBack = hlf_tick && (sweepDiv_q == 3'd0) && sweep_q[7]
                         && (sweep_q[2:0] != 3'd0) && !sweepMute;

    pulse_envelope u_envelope (
        .clk_i       (apu_clk),
        .reset_i     (reset),
        .qtr_tick_i  (qtr_tick),
        .start_i     (envStart),
        .loop_i      (ctrl_q[5]),
        .const_vol_i (ctrl_q[4]),
        .volume_i    (ctrl_q[3:0]),
        .vol_o       (volume)
    );

    always_comb begin
        ctrl_d        = ctrl_q;
        sweep_d       = sweep_q;
        periodLo_d    = periodLo_q;
        periodHi_d    = periodHi_q;
        len_d         = len_q;
        timer_d       = timer_q;
        seq_d         = seq_q;
        sweepDiv_d    = sweepDiv_q;
        sweepReload_d = sweepReload_q;

        if (sweepWriteBack) begin
            periodLo_d = sweepTarget[7:0];
            periodHi_d = sweepTarget[10:8];
        end
        if (hlf_tick) begin
            if ((sweepDiv_q == 3'd0) || sweepReload_q) begin
                sweepDiv_d    = sweep_q[6:4];
                sweepReload_d = 1'b0;
            end else begin
                sweepDiv_d = sweepDiv_q - 3'd1;
            end
        end

        if (timer_q == 11'd0) begin
            timer_d = period;
            seq_d   = seq_q - 3'd1;
        end else begin
            timer_d = timer_q - 11'd1;
        end

        if (hlf_tick && !ctrl_q[5] && (len_q != 8'd0)) begin
            len_d = len_q - 8'd1;
        end

        // A CPU write to either period register discards the whole sweep write-back.
        if (wr_en) begin
            case (wr_addr)
                REG_CTRL: ctrl_d = wr_data;
                REG_SWEEP: begin
                    sweep_d       = wr_data;
                    sweepReload_d = 1'b1;
                end
                REG_TIMER_LO: begin
                    periodLo_d = wr_data;
                    periodHi_d = periodHi_q;
                end
                REG_TIMER_HI: begin
                    periodHi_d = wr_data[2:0];
                    periodLo_d = periodLo_q;
                    seq_d      = 3'd0;
                    if (ch_enable) begin
                        len_d = len_lookup(wr_data[7:3]);
                    end
                end
                default: ;
            endcase
        end

        if (!ch_enable) begin
            len_d = 8'd0;
        end
    end

    always_comb begin
        dutyBit = DUTY_TABLE[ctrl_q[7:6]][seq_q];
        if ((len_q == 8'd0) || sweepMute) begin
            pulseOut_d = '0;
        end else if (dutyBit) begin
            pulseOut_d = OUT_W'(volume);
        end else begin
            pulseOut_d = -OUT_W'(volume);
        end
    end

    always_ff @(posedge apu_clk) begin
        if (reset) begin
            ctrl_q        <= 8'd0;
            sweep_q       <= 8'd0;
            periodLo_q    <= 8'd0;
            periodHi_q    <= 3'd0;
            len_q         <= 8'd0;
            timer_q       <= 11'd0;
            seq_q         <= 3'd0;
            sweepDiv_q    <= 3'd0;
            sweepReload_q <= 1'b0;
            active_q      <= 1'b0;
            pulseOut_q    <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            sweep_q       <= sweep_d;
            periodLo_q    <= periodLo_d;
            periodHi_q    <= periodHi_d;
            len_q         <= len_d;
            timer_q       <= timer_d;
            seq_q         <= seq_d;
            sweepDiv_q    <= sweepDiv_d;
            sweepReload_q <= sweepReload_d;
            active_q      <= (len_q != 8'd0);
            pulseOut_q    <= pulseOut_d;
        end
    end

    assign active    = active_q;
    assign pulse_out = pulseOut_q;

endmodule
